adder_arbiter: RTL and testbench

- Shares one 11-bit adder datapath between several requesters (PC increment, branch target, ALU) in the CPU.
- Round-robin grant among valid requesters; operands are latched, summed by an `ElevenBitAdder` instance, and the sum is held on a response port until consumed.
- Sits between the control unit's address/ALU request sources and the shared adder.
- Sustains one addition per cycle under continuous consumption.

---
 rtl/adder_arb_pkg.sv | 5 +
 rtl/ElevenBitAdder.sv | 8 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/adder_arbiter.sv | 62 ++++++
 tb/tb_adder_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared adder width and arbiter FSM state encoding
package adder_arb_pkg;
  localparam int ADD_WIDTH = 11;
  typedef enum logic {ARB_IDLE, ARB_RESP} arb_state_t;
endpackage

// File: rtl/ElevenBitAdder.sv
// ElevenBitAdder: 11-bit modulo adder datapath shared by the CPU requesters
module ElevenBitAdder (
  input  logic [10:0] SRC1,
  input  logic [10:0] SRC2,
  output logic [10:0] Output
);
  assign Output = SRC1 + SRC2;
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first valid index at or after ptr
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] j;
  logic found;
  // Scan from the farthest offset down so the nearest valid index overwrites last
  always_comb begin
    idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (valid[j]) begin
        idx = j;
        found = 1'b1;
      end
    end
    grant = (en && found) ? NUM_REQ'(1) << idx : '0;
  end
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one 11-bit adder with a held response port
// Optional carry-out port enabled by defining ADDER_ARB_CARRY_EN.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int WIDTH = ADD_WIDTH,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_src1,
  input  logic [NUM_REQ*WIDTH-1:0] req_src2,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [IW-1:0]            rsp_id,
`ifdef ADDER_ARB_CARRY_EN
  output logic                     rsp_carry,
`endif
  output logic [WIDTH-1:0]         rsp_sum
);
  arb_state_t state;
  logic [ADD_WIDTH-1:0] op_a, op_b, sum;
  logic [IW-1:0] rr_ptr, win;
  logic can_accept, accept;
  assign rsp_valid = state == ARB_RESP;
  assign can_accept = (state == ARB_IDLE) || (rsp_valid && rsp_ready);
  assign accept = |(req_valid & req_ready);
  // Gating on rst keeps req_ready at zero for the whole reset window
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid(req_valid),
    .ptr(rr_ptr),
    .en(can_accept && !rst),
    .grant(req_ready),
    .idx(win)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      op_a <= '0;
      op_b <= '0;
      rsp_id <= '0;
      rr_ptr <= '0;
    end else if (accept) begin
      state <= ARB_RESP;
      op_a <= req_src1[int'(win)*WIDTH +: WIDTH];
      op_b <= req_src2[int'(win)*WIDTH +: WIDTH];
      rsp_id <= win;
      rr_ptr <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end else if (rsp_ready) begin
      state <= ARB_IDLE;
    end
  end
  ElevenBitAdder u_add (.SRC1(op_a), .SRC2(op_b), .Output(sum));
  assign rsp_sum = sum;
`ifdef ADDER_ARB_CARRY_EN
  assign rsp_carry = (op_a[ADD_WIDTH-1] & op_b[ADD_WIDTH-1]) |
                     ((op_a[ADD_WIDTH-1] ^ op_b[ADD_WIDTH-1]) & ~sum[ADD_WIDTH-1]);
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: scoreboard bench for adder_arbiter (carry checked when ADDER_ARB_CARRY_EN is defined)
module tb_adder_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] req_valid, req_ready;
  logic [32:0] req_src1, req_src2;
  logic rsp_valid, rsp_ready;
  logic [1:0] rsp_id;
  logic [10:0] rsp_sum;
  logic carry_obs;
  logic [13:0] q[$];
  logic [13:0] e;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

`ifdef ADDER_ARB_CARRY_EN
  logic rsp_carry;
  assign carry_obs = rsp_carry;
`else
  assign carry_obs = 1'b0;
`endif

  adder_arbiter #(.NUM_REQ(3), .WIDTH(11)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_src1(req_src1),
    .req_src2(req_src2),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
`ifdef ADDER_ARB_CARRY_EN
    .rsp_carry(rsp_carry),
`endif
    .rsp_sum(rsp_sum)
  );

  function automatic logic [13:0] model(input int id, input logic [10:0] a, input logic [10:0] b);
    logic [11:0] f;
    f = {1'b0, a} + {1'b0, b};
`ifdef ADDER_ARB_CARRY_EN
    return {2'(id), f[10:0], f[11]};
`else
    return {2'(id), f[10:0], 1'b0};
`endif
  endfunction

  task automatic setop(input int i, input logic [10:0] a, input logic [10:0] b);
    req_src1[i*11 +: 11] = a;
    req_src2[i*11 +: 11] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    #3;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    req_src1 = '1;
    req_src2 = '1;
    req_valid = 3'b111;
    rsp_ready = 1'b1;
    rst = 1'b1;
    tick();
    n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL reset_ready got %b want 000", req_ready); end
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum, carry_obs} !== 15'd0) begin n_bad++; $display("FAIL reset_rsp got %h want 0", {rsp_valid, rsp_id, rsp_sum, carry_obs}); end
    rst = 1'b0;
    req_valid = '0;
    q.delete();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 3'b001;
    setop(0, 11'b01101110101, 11'b10011100010);
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL single_ready got %b want 001", req_ready); end
    q.push_back(model(0, 11'd885, 11'd1250));
    tick();
    req_valid = '0;
    #1;
    e = q.size() ? q.pop_front() : 'x;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum, carry_obs} !== {1'b1, e}) begin n_bad++; $display("FAIL single_rsp got %h want %h", {rsp_valid, rsp_id, rsp_sum, carry_obs}, {1'b1, e}); end
    n_cmp++; if (rsp_sum !== 11'd87) begin n_bad++; $display("FAIL single_sum87 got %0d want 87", rsp_sum); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 3'b000) begin n_bad++; $display("FAIL single_idle got v=%b r=%b want v=0 r=000", rsp_valid, req_ready); end
  endtask

  task automatic test_round_robin();
    logic [10:0] a[3], b[3];
    do_reset();
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) begin
        a[i] = 11'($urandom);
        b[i] = 11'($urandom);
        setop(i, a[i], b[i]);
      end
      #1;
      n_cmp++; if (req_ready !== 3'(1 << (k % 3))) begin n_bad++; $display("FAIL rr_grant%0d got %b want %b", k, req_ready, 3'(1 << (k % 3))); end
      if (k > 0) begin
        e = q.size() ? q.pop_front() : 'x;
        n_cmp++; if ({rsp_valid, rsp_id, rsp_sum, carry_obs} !== {1'b1, e}) begin n_bad++; $display("FAIL rr_rsp%0d got %h want %h", k, {rsp_valid, rsp_id, rsp_sum, carry_obs}, {1'b1, e}); end
      end
      q.push_back(model(k % 3, a[k % 3], b[k % 3]));
      tick();
    end
    req_valid = '0;
    #1;
    e = q.size() ? q.pop_front() : 'x;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum, carry_obs} !== {1'b1, e}) begin n_bad++; $display("FAIL rr_rsp_last got %h want %h", {rsp_valid, rsp_id, rsp_sum, carry_obs}, {1'b1, e}); end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 3'b010;
    setop(1, 11'd5, 11'd7);
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL bp_first_grant got %b want 010", req_ready); end
    q.push_back(model(1, 11'd5, 11'd7));
    tick();
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_cmp++; if (req_ready !== 3'b000) begin n_bad++; $display("FAIL bp_ready%0d got %b want 000", k, req_ready); end
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 11'd12) begin n_bad++; $display("FAIL bp_hold%0d got v=%b id=%0d sum=%0d want v=1 id=1 sum=12", k, rsp_valid, rsp_id, rsp_sum); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL bp_release_grant got %b want 010", req_ready); end
    e = q.size() ? q.pop_front() : 'x;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum, carry_obs} !== {1'b1, e}) begin n_bad++; $display("FAIL bp_rsp got %h want %h", {rsp_valid, rsp_id, rsp_sum, carry_obs}, {1'b1, e}); end
    q.push_back(model(1, 11'd5, 11'd7));
    tick();
    req_valid = '0;
    #1;
    e = q.size() ? q.pop_front() : 'x;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum, carry_obs} !== {1'b1, e}) begin n_bad++; $display("FAIL bp_rsp2 got %h want %h", {rsp_valid, rsp_id, rsp_sum, carry_obs}, {1'b1, e}); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    req_valid = 3'b001;
    setop(0, 11'b11111111111, 11'b00000000001);
    #1;
    q.push_back(model(0, 11'h7ff, 11'h001));
    tick();
    req_valid = '0;
    #1;
    e = q.size() ? q.pop_front() : 'x;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum, carry_obs} !== {1'b1, e}) begin n_bad++; $display("FAIL wrap_rsp got %h want %h", {rsp_valid, rsp_id, rsp_sum, carry_obs}, {1'b1, e}); end
    n_cmp++; if (rsp_sum !== 11'd0) begin n_bad++; $display("FAIL wrap_sum0 got %0d want 0", rsp_sum); end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req_valid = 3'b010;
    setop(1, 11'd100, 11'd200);
    setop(2, 11'd300, 11'd400);
    #1;
    tick();
    rsp_ready = 1'b0;
    #1;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_sum !== 11'd300) begin n_bad++; $display("FAIL ar_pre got v=%b sum=%0d want v=1 sum=300", rsp_valid, rsp_sum); end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_sum !== 11'd0 || req_ready !== 3'b000) begin n_bad++; $display("FAIL ar_async got v=%b sum=%0d r=%b want v=0 sum=0 r=000", rsp_valid, rsp_sum, req_ready); end
    rst = 1'b0;
    q.delete();
    #1;
    req_valid = 3'b110;
    rsp_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL ar_first_grant got %b want 010", req_ready); end
    q.push_back(model(1, 11'd100, 11'd200));
    @(posedge clk);
    #1;
    req_valid = '0;
    #1;
    e = q.size() ? q.pop_front() : 'x;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum, carry_obs} !== {1'b1, e}) begin n_bad++; $display("FAIL ar_rsp got %h want %h", {rsp_valid, rsp_id, rsp_sum, carry_obs}, {1'b1, e}); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [10:0] a, b;
    do_reset();
    req_valid = 3'b100;
    for (int k = 0; k < 3; k++) begin
      a = 11'(17 * k + 3);
      b = 11'(1000 + k);
      setop(2, a, b);
      #1;
      n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL b2b_grant%0d got %b want 100", k, req_ready); end
      if (k > 0) begin
        e = q.size() ? q.pop_front() : 'x;
        n_cmp++; if ({rsp_valid, rsp_id, rsp_sum, carry_obs} !== {1'b1, e}) begin n_bad++; $display("FAIL b2b_rsp%0d got %h want %h", k, {rsp_valid, rsp_id, rsp_sum, carry_obs}, {1'b1, e}); end
      end
      q.push_back(model(2, a, b));
      tick();
    end
    req_valid = '0;
    #1;
    e = q.size() ? q.pop_front() : 'x;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_sum, carry_obs} !== {1'b1, e}) begin n_bad++; $display("FAIL b2b_rsp_last got %h want %h", {rsp_valid, rsp_id, rsp_sum, carry_obs}, {1'b1, e}); end
    tick();
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 3'b000) begin n_bad++; $display("FAIL b2b_idle got v=%b r=%b want v=0 r=000", rsp_valid, req_ready); end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_src1 = '0;
    req_src2 = '0;
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
